// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer for the 5-stage core.
// Turns hazard-unit requests (taken branch in MEM, load-use in ID, HLT in ID)
// into per-stage write-enable / flush strobes, drains a halt through WB, and
// keeps a saturating count of load-use stall cycles for performance debug.
module pipe_ctrl_seq #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken,
    input  logic             loaduse,
    input  logic             halt_req,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             stage_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    // Drain counter must hold DRAIN_CYCLES itself.
    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [CNT_W-1:0]  stall_reg, stall_next;

    // Un-gated strobe values; reset gating is applied at the ports.
    logic pc_wen_c, ifid_wen_c, ifid_flush_c, idex_flush_c, exmem_flush_c, stage_wen_c;
    logic stall_event;

    // State, drain counter and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stall_reg <= stall_next;
        end
    end

    // Next-state logic and per-stage strobes; branch always has highest priority
    // because the branch in MEM is older than anything behind it.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        stall_event   = 1'b0;
        pc_wen_c      = 1'b1;
        ifid_wen_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        stage_wen_c   = 1'b1;

        case (state_reg)
            ST_RUN: begin
                if (branch_taken) begin
                    // Load branch target, squash the three younger instructions.
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                end else if (loaduse) begin
                    // Hold PC and IF/ID, insert a bubble into EX. A pending HLT
                    // simply stays in IF/ID and is seen again next cycle.
                    pc_wen_c     = 1'b0;
                    ifid_wen_c   = 1'b0;
                    idex_flush_c = 1'b1;
                    stall_event  = 1'b1;
                end else if (halt_req) begin
                    // HLT moves to ID/EX; stop fetching behind it.
                    pc_wen_c     = 1'b0;
                    ifid_flush_c = 1'b1;
                    cnt_next     = DRAIN_LOAD;
                    state_next   = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (branch_taken) begin
                    // An older taken branch squashes the HLT in flight.
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                    cnt_next      = '0;
                    state_next    = ST_RUN;
                end else begin
                    pc_wen_c     = 1'b0;
                    ifid_flush_c = 1'b1;
                    cnt_next     = cnt_reg - CNT_ONE;
                    if (cnt_reg <= CNT_ONE) begin
                        cnt_next   = '0;
                        state_next = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                pc_wen_c    = 1'b0;
                ifid_wen_c  = 1'b0;
                stage_wen_c = 1'b0;
            end

            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Saturating load-use stall counter.
    always_comb begin
        stall_next = stall_reg;
        if (stall_event && (stall_reg != {CNT_W{1'b1}})) begin
            stall_next = stall_reg + CNT_W'(1);
        end
    end

    // Strobes are forced low while reset is held. A flushed IF/ID must still be
    // written so the bubble actually lands.
    assign pc_wen       = rst_n & pc_wen_c;
    assign ifid_flush   = rst_n & ifid_flush_c;
    assign ifid_wen     = rst_n & (ifid_wen_c | ifid_flush_c);
    assign idex_flush   = rst_n & idex_flush_c;
    assign exmem_flush  = rst_n & exmem_flush_c;
    assign stage_wen    = rst_n & stage_wen_c;
    assign halted       = (state_reg == ST_HALTED);
    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Self-checking bench for pipe_ctrl_seq: a constant vector table, hand-written
// halt/branch/reset sequences, and random traffic against a behavioural model.
module tb_pipe_ctrl_seq;

    localparam int D = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic branch_taken, loaduse, halt_req;
    logic pc_wen, ifid_wen, ifid_flush, idex_flush, exmem_flush, stage_wen, halted;
    logic [15:0] stall_cycles;
    logic s_pc_wen, s_ifid_wen, s_ifid_flush, s_idex_flush, s_exmem_flush, s_stage_wen, s_halted;
    logic [1:0] s_stall_cycles;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_seq #(.DRAIN_CYCLES(D), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .loaduse(loaduse), .halt_req(halt_req),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .stage_wen(stage_wen),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy to exercise saturation.
    pipe_ctrl_seq #(.DRAIN_CYCLES(D), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .loaduse(loaduse), .halt_req(halt_req),
        .pc_wen(s_pc_wen), .ifid_wen(s_ifid_wen), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .stage_wen(s_stage_wen),
        .halted(s_halted), .stall_cycles(s_stall_cycles)
    );

    wire [5:0] outs   = {pc_wen, ifid_wen, ifid_flush, idex_flush, exmem_flush, stage_wen};
    wire [5:0] s_outs = {s_pc_wen, s_ifid_wen, s_ifid_flush, s_idex_flush, s_exmem_flush, s_stage_wen};

    // Behavioural model: halted flag, cycles left until HLT retires, stall tallies.
    bit m_halted;
    int m_drain_left;
    int m_stall;
    int m_stall_sat;

    task automatic m_reset();
        m_halted = 0; m_drain_left = 0; m_stall = 0; m_stall_sat = 0;
    endtask

    // Strobes as {pc, ifid_wen, ifid_flush, idex_flush, exmem_flush, stage_wen}.
    function automatic logic [5:0] m_expect(input logic b, input logic l, input logic h);
        if (m_halted)              return 6'b000000;
        if (b)                     return 6'b111111;
        if (m_drain_left > 0)      return 6'b011001;
        if (l)                     return 6'b000101;
        if (h)                     return 6'b011001;
        return 6'b110001;
    endfunction

    task automatic m_update(input logic b, input logic l, input logic h);
        if (m_halted) return;
        if (b) begin
            m_drain_left = 0;
        end else if (m_drain_left > 0) begin
            if (m_drain_left == 1) m_halted = 1;
            m_drain_left--;
        end else if (l) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall_sat < 3) m_stall_sat++;
        end else if (h) begin
            m_drain_left = D;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's requests at the falling edge and sample 1 time unit later.
    task automatic apply(input logic b, input logic l, input logic h);
        @(negedge clk);
        branch_taken = b; loaduse = l; halt_req = h;
        #1;
        cyc++;
        $display("cyc=%0d b=%b l=%b h=%b strobes=%b halted=%b stall=%0d sat=%0d",
                 cyc, b, l, h, outs, halted, stall_cycles, s_stall_cycles);
    endtask

    // Compare against the model, then let the rising edge commit the cycle.
    task automatic step(input logic b, input logic l, input logic h);
        apply(b, l, h);
        chk("strobes", 32'(outs), 32'(m_expect(b, l, h)));
        chk("sat_strobes", 32'(s_outs), 32'(m_expect(b, l, h)));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("stall", 32'(stall_cycles), 32'(m_stall));
        chk("stall_sat", 32'(s_stall_cycles), 32'(m_stall_sat));
        @(posedge clk);
        m_update(b, l, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; branch_taken = 0; loaduse = 0; halt_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic       b, l, h;
        logic [5:0] strobes;
        logic       halted;
        int         stall;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; branch_taken = 0; loaduse = 0; halt_req = 0;
        m_reset();

        // Strobes while held in reset must be zero.
        #2;
        chk("reset_strobes", 32'(outs), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        chk("reset_stall", 32'(stall_cycles), 32'h0);
        do_reset();

        // Constant vectors from reset: idle, 2 stalls, all-three-at-once, halt drain.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 6'b110001, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'b110001, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 6'b000101, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'b000101, 1'b0, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b110001, 1'b0, 2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 6'b111111, 1'b0, 2};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b110001, 1'b0, 2};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 6'b011001, 1'b0, 2};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 6'b011001, 1'b0, 2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b011001, 1'b0, 2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 6'b011001, 1'b0, 2};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 6'b000000, 1'b1, 2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 6'b000000, 1'b1, 2};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 6'b000000, 1'b1, 2};
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].b, tbl[i].l, tbl[i].h);
            chk("tbl_strobes", 32'(outs), 32'(tbl[i].strobes));
            chk("tbl_halted", 32'(halted), 32'(tbl[i].halted));
            chk("tbl_stall", 32'(stall_cycles), 32'(tbl[i].stall));
            @(posedge clk);
            m_update(tbl[i].b, tbl[i].l, tbl[i].h);
        end

        // Saturation of the 2-bit counter: 5 stalls -> 3.
        do_reset();
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_value", 32'(s_stall_cycles), 32'd3);
        chk("wide_value", 32'(stall_cycles), 32'd5);

        // Branch during DRAIN kills the halt.
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        chk("kill_strobes", 32'(outs), 32'h3f);
        @(posedge clk);
        m_update(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("kill_run", 32'(outs), 32'h31);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("kill_no_halt", 32'(halted), 32'h0);

        // Branch in the very cycle DRAIN would finish: branch wins.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("late_kill_halted", 32'(halted), 32'h0);

        // Reset asserted mid-drain (cnt=2), released 2 cycles later.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'(outs), 32'h0);
        chk("rst_mid_stall", 32'(stall_cycles), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_strobes", 32'(outs), 32'h0);
        rst_n = 1'b1;
        m_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("rst_after_run", 32'(outs), 32'h31);

        // Random traffic against the model; reset now and then once halted.
        for (int n = 0; n < 400; n++) begin
            logic rb, rl, rh;
            rb = ($urandom_range(7) == 0);
            rl = ($urandom_range(3) == 0);
            rh = ($urandom_range(9) == 0);
            if (m_halted && ($urandom_range(3) == 0)) do_reset();
            step(rb, rl, rh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_seq.md
# pipe_ctrl_seq

Pipeline control sequencer: consumes the hazard unit's requests (taken branch in MEM, load-use in ID, halt decode in ID) and turns them into per-stage write-enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It owns the halt drain state machine, so that a halt retires cleanly through WB, and a saturating stall-cycle counter for performance debug. It sits between the hazard detection logic and every pipeline register in the 5-stage CPU.

## Interface
- DRAIN_CYCLES, 3, cycles after halt leaves ID until it has retired from WB (min 1)
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- branch_taken  in  1  branch in MEM resolved taken this cycle
- loaduse  in  1  load-use hazard between ID and EX this cycle
- halt_req  in  1  instruction in IF/ID decodes as HLT
- pc_wen  out  1  PC register load enable
- ifid_wen  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID loads bubble
- idex_flush  out  1  ID/EX loads bubble
- exmem_flush  out  1  EX/MEM loads bubble
- stage_wen  out  1  ID/EX, EX/MEM, MEM/WB write enable
- halted  out  1  CPU stopped, sticky until reset
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles

## Operation
- States: RUN, DRAIN, HALTED. 2-bit state plus drain counter cnt (ceil(log2(DRAIN_CYCLES+1)) bits).
- Strobes are combinational from state and inputs, and act in the same cycle. halted, stall_cycles, state and cnt are registered.
- RUN priority: branch_taken > loaduse > halt_req. Default is all wen 1, all flushes 0.
- RUN + branch_taken:
  - pc_wen=1 to load the target.
  - ifid_flush=idex_flush=exmem_flush=1.
  - Stay in RUN. halt_req and loaduse are ignored this cycle.
- RUN + loaduse (no branch):
  - pc_wen=0, ifid_wen=0, idex_flush=1, stage_wen=1.
  - stall_cycles increments, saturating at all-ones.
  - Stay in RUN. A simultaneous halt_req is deferred: HLT stays in IF/ID and is re-presented.
- RUN + halt_req only:
  - pc_wen=0, ifid_flush=1, stage_wen=1. HLT advances to ID/EX.
  - cnt<=DRAIN_CYCLES, go to DRAIN.
- DRAIN:
  - pc_wen=0, ifid_flush=1, stage_wen=1. cnt decrements each cycle.
  - When cnt==1 and no branch_taken, go to HALTED.
  - halt_req and loaduse are ignored.
- DRAIN + branch_taken, at any cnt: the older branch kills the halt.
  - Emit the branch strobes (pc_wen=1, three flushes).
  - cnt<=0, return to RUN. halted stays 0.
- HALTED:
  - pc_wen=ifid_wen=stage_wen=0, all flushes 0, halted=1.
  - All inputs are ignored. Only rst_n exits this state.
- ifid_wen=1 whenever ifid_flush=1, because the bubble must be written.

## Timing
- Reset values: state=RUN, cnt=0, halted=0, stall_cycles=0.
- While rst_n is low, all wen and flush outputs are 0.
- After rst_n deasserts, RUN defaults apply on the first cycle.
- Reset asserted mid-DRAIN or in HALTED returns to RUN asynchronously.
- Halt at cycle T in RUN:
  - DRAIN covers T+1..T+DRAIN_CYCLES.
  - halted=1 from T+DRAIN_CYCLES+1.
  - With default 3: HLT is in ID/EX at T+1, EX/MEM at T+2, MEM/WB at T+3, and halted is high at T+4.
- Load-use stalls last exactly one cycle per loaduse assertion. Back-to-back assertions give back-to-back stalls.
- branch_taken in the same cycle as the DRAIN→HALTED transition: the branch wins, next state is RUN.
- stall_cycles updates at the clock edge after the stalled cycle and holds at 2^CNT_W-1.

## Test plan
- Reset, then all inputs 0 for 5 cycles -> pc_wen=ifid_wen=stage_wen=1, all flushes 0, halted=0, stall_cycles=0.
- loaduse for 2 consecutive cycles -> pc_wen=0, ifid_wen=0 and idex_flush=1 in both cycles, stall_cycles=2 afterwards. With CNT_W=2 and 5 stalls, the count saturates at 3.
- halt_req at T=10, default parameter -> pc_wen=0 and ifid_flush=1 at T=10..13, halted=1 at T=14, all wen 0 from T=14. Later branch_taken/halt_req pulses have no effect.
- halt_req at T=10, branch_taken at T=12 -> at T=12 pc_wen=1 and ifid/idex/exmem flush=1, state RUN at T=13, halted never rises.
- branch_taken, loaduse and halt_req together at T=5 -> branch strobes only, stall_cycles unchanged, no DRAIN.
- rst_n low at DRAIN cnt=2, released 2 cycles later -> outputs 0 during reset, then RUN defaults, halted=0, stall_cycles=0.
